rgb8bit_quantizer: RTL and testbench



---
 rtl/rgb8bit_quantizer.sv | 175 +++++++++++++++++
 tb/tb_rgb8bit_quantizer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb8bit_quantizer.sv
// rgb8bit_quantizer: folds an RGB888 pixel back to the nearest 4-bit DAC code per channel
// using a 4-step binary search over the fixed DAC level table, all channels in parallel.
module rgb8bit_quantizer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] R_8BIT,
  input  logic [7:0] G_8BIT,
  input  logic [7:0] B_8BIT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [3:0] R_4BIT,
  output logic [3:0] G_4BIT,
  output logic [3:0] B_4BIT
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S3   = 3'd1,
    S2   = 3'd2,
    S1   = 3'd3,
    S0   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] r_lat_r;
  logic [7:0] g_lat_r;
  logic [7:0] b_lat_r;
  logic [3:0] r_acc_r;
  logic [3:0] g_acc_r;
  logic [3:0] b_acc_r;
  logic [3:0] r_step_s;
  logic [3:0] g_step_s;
  logic [3:0] b_step_s;
  logic [1:0] bit_pos_s;
  logic       searching_s;
  logic       accept_s;

  // Forward DAC curve; must stay bit-exact with the output DAC.
  function automatic logic [7:0] dac_level(input logic [3:0] code);
    case (code)
      4'd0:    dac_level = 8'h00;
      4'd1:    dac_level = 8'h0B;
      4'd2:    dac_level = 8'h1C;
      4'd3:    dac_level = 8'h2E;
      4'd4:    dac_level = 8'h42;
      4'd5:    dac_level = 8'h51;
      4'd6:    dac_level = 8'h62;
      4'd7:    dac_level = 8'h70;
      4'd8:    dac_level = 8'h92;
      4'd9:    dac_level = 8'hA1;
      4'd10:   dac_level = 8'hB1;
      4'd11:   dac_level = 8'hC0;
      4'd12:   dac_level = 8'hD4;
      4'd13:   dac_level = 8'hE3;
      4'd14:   dac_level = 8'hF4;
      4'd15:   dac_level = 8'hFF;
      default: dac_level = 8'h00;
    endcase
  endfunction

  // Trial code is kept only when 2*v lies strictly above the midpoint, so ties fall to the lower code.
  function automatic logic [3:0] search_step(input logic [7:0] v, input logic [3:0] acc,
                                             input logic [1:0] bit_pos);
    logic [3:0] trial;
    logic [8:0] mid_sum;
    trial   = acc | (4'd1 << bit_pos);
    mid_sum = {1'b0, dac_level(trial - 4'd1)} + {1'b0, dac_level(trial)};
    if ({v, 1'b0} > mid_sum) begin
      search_step = trial;
    end else begin
      search_step = acc;
    end
  endfunction

  assign IN_READY = (state_r == IDLE) || ((state_r == DONE) && OUT_READY);
  assign accept_s = IN_VALID && IN_READY;
  assign r_step_s = search_step(r_lat_r, r_acc_r, bit_pos_s);
  assign g_step_s = search_step(g_lat_r, g_acc_r, bit_pos_s);
  assign b_step_s = search_step(b_lat_r, b_acc_r, bit_pos_s);

  always_comb begin
    state_nxt_s = state_r;
    bit_pos_s   = 2'd0;
    searching_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = S3;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      S3: begin
        bit_pos_s   = 2'd3;
        searching_s = 1'b1;
        state_nxt_s = S2;
      end
      S2: begin
        bit_pos_s   = 2'd2;
        searching_s = 1'b1;
        state_nxt_s = S1;
      end
      S1: begin
        bit_pos_s   = 2'd1;
        searching_s = 1'b1;
        state_nxt_s = S0;
      end
      S0: begin
        bit_pos_s   = 2'd0;
        searching_s = 1'b1;
        state_nxt_s = DONE;
      end
      DONE: begin
        if (!OUT_READY) begin
          state_nxt_s = DONE;
        end else if (IN_VALID) begin
          state_nxt_s = S3;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch on accept, refine acc per step, publish results on leaving S0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_r   <= 8'd0;
      g_lat_r   <= 8'd0;
      b_lat_r   <= 8'd0;
      r_acc_r   <= 4'd0;
      g_acc_r   <= 4'd0;
      b_acc_r   <= 4'd0;
      R_4BIT    <= 4'd0;
      G_4BIT    <= 4'd0;
      B_4BIT    <= 4'd0;
      OUT_VALID <= 1'b0;
    end else begin
      if (accept_s) begin
        r_lat_r <= R_8BIT;
        g_lat_r <= G_8BIT;
        b_lat_r <= B_8BIT;
        r_acc_r <= 4'd0;
        g_acc_r <= 4'd0;
        b_acc_r <= 4'd0;
      end else if (searching_s) begin
        r_acc_r <= r_step_s;
        g_acc_r <= g_step_s;
        b_acc_r <= b_step_s;
      end
      if (state_r == S0) begin
        R_4BIT    <= r_step_s;
        G_4BIT    <= g_step_s;
        B_4BIT    <= b_step_s;
        OUT_VALID <= 1'b1;
      end else if ((state_r == DONE) && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb8bit_quantizer.sv
// Self-checking bench for rgb8bit_quantizer: directed scenarios plus a randomized sweep
// compared against a nearest-level reference model.
module tb_rgb8bit_quantizer;

  logic       clk;
  logic       reset_n;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] R_8BIT;
  logic [7:0] G_8BIT;
  logic [7:0] B_8BIT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] R_4BIT;
  logic [3:0] G_4BIT;
  logic [3:0] B_4BIT;

  int tests_run;
  int fails;

  logic [7:0] tbl [16] = '{8'h00, 8'h0B, 8'h1C, 8'h2E, 8'h42, 8'h51, 8'h62, 8'h70,
                           8'h92, 8'hA1, 8'hB1, 8'hC0, 8'hD4, 8'hE3, 8'hF4, 8'hFF};

  rgb8bit_quantizer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .R_8BIT    (R_8BIT),
    .G_8BIT    (G_8BIT),
    .B_8BIT    (B_8BIT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .R_4BIT    (R_4BIT),
    .G_4BIT    (G_4BIT),
    .B_4BIT    (B_4BIT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exhaustive nearest-level search, strict '<' keeps the lower code on ties.
  function automatic logic [3:0] nearest(input logic [7:0] v);
    int best;
    int bd;
    int d;
    best = 0;
    bd   = 1000;
    for (int c = 0; c < 16; c++) begin
      d = int'(v) - int'(tbl[c]);
      if (d < 0) d = -d;
      if (d < bd) begin
        bd   = d;
        best = c;
      end
    end
    return best[3:0];
  endfunction

  // One full transaction: accept, latency, result, optional stall, then release.
  task automatic do_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb,
                          input int stall);
    int n;
    @(negedge clk);
    IN_VALID  = 1'b1;
    R_8BIT    = r;
    G_8BIT    = g;
    B_8BIT    = b;
    OUT_READY = 1'b0;
    n = 0;
    while (!IN_READY && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: IN_READY=%b required 1", IN_READY);
    end
    @(negedge clk);
    IN_VALID = 1'b0;
    R_8BIT   = 8'($urandom);
    G_8BIT   = 8'($urandom);
    B_8BIT   = 8'($urandom);
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      fails++;
      $display("FAIL latency: %0d edges after accept, required 4", n);
    end
    tests_run++;
    if ({R_4BIT, G_4BIT, B_4BIT} !== {er, eg, eb}) begin
      fails++;
      $display("FAIL codes in=%h/%h/%h: got %h/%h/%h required %h/%h/%h",
               r, g, b, R_4BIT, G_4BIT, B_4BIT, er, eg, eb);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      tests_run++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || {R_4BIT, G_4BIT, B_4BIT} !== {er, eg, eb}) begin
        fails++;
        $display("FAIL stall_hold: valid=%b in_ready=%b codes=%h/%h/%h required 1/0/%h/%h/%h",
                 OUT_VALID, IN_READY, R_4BIT, G_4BIT, B_4BIT, er, eg, eb);
      end
    end
    OUT_READY = 1'b1;
    @(negedge clk);
    OUT_READY = 1'b0;
    tests_run++;
    if (OUT_VALID !== 1'b0) begin
      fails++;
      $display("FAIL release: OUT_VALID=%b required 0", OUT_VALID);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    R_8BIT    = 8'd0;
    G_8BIT    = 8'd0;
    B_8BIT    = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || {R_4BIT, G_4BIT, B_4BIT} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: valid=%b in_ready=%b codes=%h/%h/%h required 0/1/0/0/0",
               OUT_VALID, IN_READY, R_4BIT, G_4BIT, B_4BIT);
    end
  endtask

  task automatic test_round_trip();
    for (int c = 0; c < 16; c++) begin
      do_pixel(tbl[c], tbl[c], tbl[c], 4'(c), 4'(c), 4'(c), 0);
    end
  endtask

  task automatic test_ties();
    do_pixel(8'h81, 8'h82, 8'h05, 4'd7, 4'd8, 4'd0, 1);
    do_pixel(8'h00, 8'hFF, 8'h06, 4'd0, 4'd15, 4'd1, 0);
    do_pixel(8'h80, 8'hEB, 8'h3C, 4'd7, 4'd13, 4'd4, 2);
  endtask

  task automatic test_reset_midflight();
    do_pixel(8'hFF, 8'hFF, 8'hFF, 4'd15, 4'd15, 4'd15, 0);
    @(negedge clk);
    IN_VALID = 1'b1;
    R_8BIT   = 8'h80;
    G_8BIT   = 8'h80;
    B_8BIT   = 8'h80;
    @(negedge clk);
    IN_VALID = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (OUT_VALID !== 1'b0 || {R_4BIT, G_4BIT, B_4BIT} !== 12'h000) begin
      fails++;
      $display("FAIL midflight_reset: valid=%b codes=%h/%h/%h required 0/0/0/0",
               OUT_VALID, R_4BIT, G_4BIT, B_4BIT);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL midflight_ready: IN_READY=%b required 1", IN_READY);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (OUT_VALID !== 1'b0) begin
        fails++;
        $display("FAIL spurious_result: OUT_VALID=%b required 0 at cycle %0d", OUT_VALID, i);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    IN_VALID  = 1'b1;
    R_8BIT    = 8'h80;
    G_8BIT    = 8'hEB;
    B_8BIT    = 8'h3C;
    OUT_READY = 1'b0;
    @(negedge clk);
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      fails++;
      $display("FAIL bp_latency1: %0d edges, required 4", n);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || {R_4BIT, G_4BIT, B_4BIT} !== {4'd7, 4'd13, 4'd4}) begin
        fails++;
        $display("FAIL bp_hold: valid=%b in_ready=%b codes=%h/%h/%h required 1/0/7/d/4",
                 OUT_VALID, IN_READY, R_4BIT, G_4BIT, B_4BIT);
      end
    end
    IN_VALID  = 1'b1;
    R_8BIT    = 8'h81;
    G_8BIT    = 8'h82;
    B_8BIT    = 8'h06;
    OUT_READY = 1'b1;
    #1;
    tests_run++;
    if (IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL bp_ready_pulse: IN_READY=%b required 1", IN_READY);
    end
    @(negedge clk);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    R_8BIT    = 8'h00;
    tests_run++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0) begin
      fails++;
      $display("FAIL bp_same_edge_accept: valid=%b in_ready=%b required 0/0", OUT_VALID, IN_READY);
    end
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      fails++;
      $display("FAIL bp_latency2: %0d edges, required 4", n);
    end
    tests_run++;
    if ({R_4BIT, G_4BIT, B_4BIT} !== {4'd7, 4'd8, 4'd1}) begin
      fails++;
      $display("FAIL bp_codes2: got %h/%h/%h required 7/8/1", R_4BIT, G_4BIT, B_4BIT);
    end
    OUT_READY = 1'b1;
    @(negedge clk);
    OUT_READY = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] mg;
    logic [7:0] mb;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    mg = 8'($urandom);
    mb = 8'($urandom);
    for (int v = 0; v < 256; v++) begin
      r = 8'(v);
      g = r ^ mg;
      b = ~r ^ mb;
      do_pixel(r, g, b, nearest(r), nearest(g), nearest(b), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_round_trip();
    test_reset_midflight();
    test_ties();
    test_backpressure();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
